// File: rtl/usb_in_arbiter.sv
// usb_in_arbiter: round-robin burst arbiter sharing one usb_cdc IN byte stream among N_REQ sources.
// Define ARB_TAG_EN to prefix every burst with an owner tag byte 8'hF0|g.
module usb_in_arbiter #(
    parameter int N_REQ     = 2,
    parameter int BURST_LEN = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [8*N_REQ-1:0] req_data_i,
    input  logic [N_REQ-1:0]   req_valid_i,
    output logic [N_REQ-1:0]   req_ready_o,
    output logic [7:0]         out_data_o,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [N_REQ-1:0]   grant_o,
    output logic               busy_o
);
    localparam int IW = $clog2(N_REQ);
    localparam int CW = $clog2(BURST_LEN + 1);

    typedef enum logic [1:0] {IDLE, TAG, XFER} state_t;

    state_t           state_q, state_d;
    logic [IW-1:0]    g_q, g_d, rr_q, rr_d, pick, idx, g_nxt;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic             pick_vld, own_vld, hs, last;
    logic [7:0]       src_data [N_REQ];

    for (genvar k = 0; k < N_REQ; k++) begin : g_unpack
        assign src_data[k] = req_data_i[8*k +: 8];
    end

    // Scan downward so the source closest to rr_q is the last (winning) assignment.
    always_comb begin
        pick_vld = 1'b0;
        pick     = '0;
        idx      = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            idx = IW'((int'(rr_q) + i) % N_REQ);
            if (req_valid_i[idx]) begin
                pick_vld = 1'b1;
                pick     = idx;
            end
        end
    end

    assign own_vld = req_valid_i[g_q];
    assign hs      = own_vld & out_ready_i;
    assign last    = cnt_q == CW'(BURST_LEN - 1);
    assign g_nxt   = IW'((int'(g_q) + 1) % N_REQ);
    assign grant_o = grant_q;
    assign busy_o  = state_q != IDLE;

    always_comb begin
        state_d     = state_q;
        g_d         = g_q;
        rr_d        = rr_q;
        cnt_d       = cnt_q;
        grant_d     = grant_q;
        out_data_o  = '0;
        out_valid_o = 1'b0;
        req_ready_o = '0;
        unique case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    g_d     = pick;
                    grant_d = N_REQ'(1) << pick;
                    cnt_d   = '0;
`ifdef ARB_TAG_EN
                    state_d = TAG;
`else
                    state_d = XFER;
`endif
                end
            end
`ifdef ARB_TAG_EN
            TAG: begin
                out_data_o  = 8'hF0 | 8'(g_q);
                out_valid_o = 1'b1;
                state_d     = out_ready_i ? XFER : TAG;
            end
`endif
            XFER: begin
                out_data_o  = src_data[g_q];
                out_valid_o = own_vld;
                req_ready_o = N_REQ'(hs) << g_q;
                cnt_d       = hs ? cnt_q + CW'(1) : cnt_q;
                // Burst ends on the last allowed handshake or when the owner runs dry.
                if (!own_vld || (hs && last)) begin
                    state_d = IDLE;
                    rr_d    = g_nxt;
                    grant_d = '0;
                    cnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            g_q     <= '0;
            rr_q    <= '0;
            cnt_q   <= '0;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
        end
    end
endmodule
